// File: rtl/memc_pkg.sv
// Shared types and constants for the memc_bist controller and its RAM.
package memc_pkg;

    // One-hot controller states.
    typedef enum logic [10:0] {
        S_INIT  = 11'h001,
        S_WR1   = 11'h002,
        S_RD1   = 11'h004,
        S_CHK1  = 11'h008,
        S_WR2   = 11'h010,
        S_RD2   = 11'h020,
        S_CHK2  = 11'h040,
        S_ERROR = 11'h080,
        S_IDLE  = 11'h100,
        S_READ  = 11'h200,
        S_WRITE = 11'h400
    } state_t;

    localparam logic [7:0] PATT_BASE = 8'h55;

    // Returns PATT_BASE replicated over data_w bits (n=0), or its inverse (n=1).
    // Bits at and above data_w are zero.
    function automatic logic [63:0] patt(input logic n, input int data_w);
        logic [63:0] p;
        p = {8{PATT_BASE}};
        if (n) p = ~p;
        for (int i = 0; i < 64; i++) begin
            if (i >= data_w) p[i] = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/memc_bist_spram.sv
// Single-port RAM, one-cycle synchronous read, read-first, no reset on the array.
module spram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]  idx;

    // Callers only enable the RAM for in-range addresses, so the low bits suffice.
    assign idx = addr[IDX_W-1:0];

    generate
        if (IDX_W < ADDR_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // Write and registered read on the same enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[idx] <= din;
            dout <= mem[idx];
        end
    end

endmodule

// File: rtl/memc_bist.sv
// Memory controller with power-on two-pattern BIST, then single-beat host access.
module memc_bist
    import memc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int BIST_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              bist_start,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bist_done,
    output logic              bist_error,
    output logic [ADDR_W-1:0] bist_fail_addr
);
    localparam logic [DATA_W-1:0] P1      = DATA_W'(patt(1'b0, DATA_W));
    localparam logic [DATA_W-1:0] P2      = DATA_W'(patt(1'b1, DATA_W));
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] bist_addr;
    logic              rd_oor;
    logic              rd_wait;
    logic              in_range;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    assign in_range = ({1'b0, addr} < DEPTH_X);

    // RAM port steering: BIST owns it in test states, host owns it at accept in IDLE.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = bist_addr;
        ram_din  = P1;
        unique case (state)
            S_WR1: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            S_RD1: ram_en = 1'b1;
            S_WR2: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = P2;
            end
            S_RD2: ram_en = 1'b1;
            S_IDLE: begin
                if (!bist_start && read_en) begin
                    ram_en   = in_range;
                    ram_addr = addr;
                end else if (!bist_start && write_en) begin
                    ram_en   = in_range;
                    ram_we   = in_range;
                    ram_addr = addr;
                    ram_din  = wdata;
                end
            end
            default: ;
        endcase
    end

    spram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Controller FSM with registered status and read-data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_INIT;
            busy           <= 1'b1;
            rdata          <= '0;
            rdata_valid    <= 1'b0;
            bist_done      <= 1'b0;
            bist_error     <= 1'b0;
            bist_fail_addr <= '0;
            bist_addr      <= '0;
            rd_oor         <= 1'b0;
            rd_wait        <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (BIST_EN != 0) begin
                        state <= S_WR1;
                    end else begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        bist_done <= 1'b1;
                    end
                end
                S_WR1: state <= S_RD1;
                S_RD1: state <= S_CHK1;
                S_CHK1: begin
                    if (ram_dout != P1) begin
                        state          <= S_ERROR;
                        bist_error     <= 1'b1;
                        bist_fail_addr <= bist_addr;
                    end else begin
                        state <= S_WR2;
                    end
                end
                S_WR2: state <= S_RD2;
                S_RD2: state <= S_CHK2;
                S_CHK2: begin
                    if (ram_dout != P2) begin
                        state          <= S_ERROR;
                        bist_error     <= 1'b1;
                        bist_fail_addr <= bist_addr;
                    end else if (bist_addr == LAST_A) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        bist_done <= 1'b1;
                        bist_addr <= '0;
                    end else begin
                        state     <= S_WR1;
                        bist_addr <= bist_addr + 1'b1;
                    end
                end
                S_ERROR: state <= S_ERROR;
                S_IDLE: begin
                    if (bist_start) begin
                        state     <= S_WR1;
                        busy      <= 1'b1;
                        bist_done <= 1'b0;
                        bist_addr <= '0;
                    end else if (read_en) begin
                        state   <= S_READ;
                        busy    <= 1'b1;
                        rd_oor  <= !in_range;
                        rd_wait <= 1'b1;
                    end else if (write_en) begin
                        state <= S_WRITE;
                        busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    // RAM output holds while disabled; capture on the second READ cycle.
                    if (rd_wait) begin
                        rd_wait <= 1'b0;
                    end else begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        rdata       <= rd_oor ? '0 : ram_dout;
                        rdata_valid <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memc_bist.sv
// Randomized bench for memc_bist with a cycle-level behavioural model.
module tb_memc_bist;
    localparam int D       = 16;
    localparam int FAULT_A = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic        bist_start = 1'b0;
    logic        busy;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        bist_done;
    logic        bist_error;
    logic [15:0] bist_fail_addr;

    logic        r12 = 1'b0;
    logic [3:0]  a12 = 4'd0;
    logic        busy12;
    logic [11:0] rdata12;
    logic        rv12;
    logic        done12;
    logic        err12;
    logic [3:0]  fail12;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    memc_bist #(.ADDR_W(16), .DATA_W(8), .DEPTH(D), .BIST_EN(1)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .read_en(read_en), .write_en(write_en), .bist_start(bist_start),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
        .bist_done(bist_done), .bist_error(bist_error),
        .bist_fail_addr(bist_fail_addr)
    );

    memc_bist #(.ADDR_W(4), .DATA_W(12), .DEPTH(4), .BIST_EN(1)) dut12 (
        .clk(clk), .reset(reset), .addr(a12), .wdata(12'h000),
        .read_en(r12), .write_en(1'b0), .bist_start(1'b0),
        .busy(busy12), .rdata(rdata12), .rdata_valid(rv12),
        .bist_done(done12), .bist_error(err12),
        .bist_fail_addr(fail12)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 self-test running, 1 idle, 2 failed, 3 host access in flight
    int          mode = 0;
    int          bist_t = 0;
    int          left = 0;
    logic        h_rd = 1'b0;
    logic [15:0] h_addr = '0;
    logic        fault_en = 1'b0;
    logic        started = 1'b0;
    logic        m_busy = 1'b1;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_fail = '0;
    logic [7:0]  m_rdata = '0;
    logic        m_rv = 1'b0;
    logic [7:0]  mem [0:D-1];

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            mode = 0; bist_t = 0; m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
            m_fail = '0; m_rdata = '0; m_rv = 1'b0;
        end else begin
            m_rv = 1'b0;
            case (mode)
                0: begin
                    bist_t++;
                    if (fault_en && bist_t == 7 + 6*FAULT_A) begin
                        mode = 2; m_err = 1'b1; m_fail = 16'(FAULT_A);
                    end else if (bist_t == 1 + 6*D) begin
                        mode = 1; m_done = 1'b1; m_busy = 1'b0;
                        for (int i = 0; i < D; i++) mem[i] = 8'hAA;
                    end
                end
                1: begin
                    if (bist_start) begin
                        m_done = 1'b0; m_busy = 1'b1; mode = 0; bist_t = 1;
                    end else if (read_en) begin
                        mode = 3; left = 2; h_rd = 1'b1; h_addr = addr; m_busy = 1'b1;
                    end else if (write_en) begin
                        if (addr < 16'(D)) mem[addr[3:0]] = wdata;
                        mode = 3; left = 1; h_rd = 1'b0; m_busy = 1'b1;
                    end
                end
                3: begin
                    left--;
                    if (left == 0) begin
                        mode = 1; m_busy = 1'b0;
                        if (h_rd) begin
                            m_rdata = (h_addr < 16'(D)) ? mem[h_addr[3:0]] : 8'h00;
                            m_rv = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("bist_done", 32'(bist_done), 32'(m_done));
            chk("bist_error", 32'(bist_error), 32'(m_err));
            chk("bist_fail_addr", 32'(bist_fail_addr), 32'(m_fail));
            chk("rdata_valid", 32'(rdata_valid), 32'(m_rv));
            chk("rdata", 32'(rdata), 32'(m_rdata));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_done", 32'(bist_done), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;

        // Power-on self-test: done exactly at edge 97.
        repeat (96) @(negedge clk);
        chk("done_before_97", 32'(bist_done), 32'd0);
        @(negedge clk);
        chk("done_at_97", 32'(bist_done), 32'd1);
        chk("busy_at_97", 32'(busy), 32'd0);
        chk("err_at_97", 32'(bist_error), 32'd0);

        // 12-bit instance: memory holds the inverted pattern after self-test.
        r12 = 1'b1; a12 = 4'd1;
        @(negedge clk); r12 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w12_rv", 32'(rv12), 32'd1);
        chk("w12_rdata", 32'(rdata12), 32'hAAA);
        chk("w12_done", 32'(done12), 32'd1);

        // Write C3 to address 7, then read it back.
        write_en = 1'b1; addr = 16'd7; wdata = 8'hC3;
        @(negedge clk); write_en = 1'b0;
        chk("wr_busy_k", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_busy_k1", 32'(busy), 32'd0);
        read_en = 1'b1;
        @(negedge clk); read_en = 1'b0;
        @(negedge clk);
        chk("rd_busy_k3", 32'(busy), 32'd1);
        chk("rd_rv_k3", 32'(rdata_valid), 32'd0);
        @(negedge clk);
        chk("rd_rv_k4", 32'(rdata_valid), 32'd1);
        chk("rd_c3", 32'(rdata), 32'hC3);

        // Simultaneous read and write: read wins, write dropped.
        write_en = 1'b1; addr = 16'd2; wdata = 8'h11;
        @(negedge clk); write_en = 1'b0;
        @(negedge clk);
        read_en = 1'b1; write_en = 1'b1; wdata = 8'hFF;
        @(negedge clk); read_en = 1'b0; write_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("sim_rdata", 32'(rdata), 32'h11);
        read_en = 1'b1;
        @(negedge clk); read_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("sim_keep", 32'(rdata), 32'h11);

        // Out-of-range read returns zero with a valid strobe.
        read_en = 1'b1; addr = 16'd100;
        @(negedge clk); read_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("oor_rv", 32'(rdata_valid), 32'd1);
        chk("oor_rdata", 32'(rdata), 32'd0);

        // Re-run self-test on request.
        bist_start = 1'b1;
        @(negedge clk); bist_start = 1'b0;
        chk("rerun_drop", 32'(bist_done), 32'd0);
        repeat (95) @(negedge clk);
        chk("rerun_before", 32'(bist_done), 32'd0);
        @(negedge clk);
        chk("rerun_done", 32'(bist_done), 32'd1);

        // Randomized host traffic, occasional self-test re-runs.
        for (int i = 0; i < 600; i++) begin
            read_en    = 1'($urandom_range(0, 1));
            write_en   = 1'($urandom_range(0, 1));
            addr       = 16'($urandom_range(0, 19));
            wdata      = 8'($urandom);
            bist_start = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        read_en = 1'b0; write_en = 1'b0; bist_start = 1'b0;
        repeat (110) @(negedge clk);

        // Reset in WR2 of address 9, then a full self-test.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (58) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (96) @(negedge clk);
        chk("mid_before", 32'(bist_done), 32'd0);
        @(negedge clk);
        chk("mid_done", 32'(bist_done), 32'd1);

        // Fault at address 5 during the second compare.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; fault_en = 1'b1;
        repeat (36) @(negedge clk);
        force dut.u_ram.dout = 8'hA2;
        @(negedge clk);
        release dut.u_ram.dout;
        chk("fault_err", 32'(bist_error), 32'd1);
        chk("fault_addr", 32'(bist_fail_addr), 32'd5);
        chk("fault_done", 32'(bist_done), 32'd0);
        read_en = 1'b1; addr = 16'd3;
        repeat (4) begin
            @(negedge clk);
            chk("err_busy", 32'(busy), 32'd1);
            chk("err_rv", 32'(rdata_valid), 32'd0);
        end
        read_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
